mdu_scheduler: RTL and testbench

Sequences the pipelined 32x32 multiplier for the EX stage and owns the architectural HI/LO registers. It accepts MULT/MULTU/MTHI/MTLO requests and launches multiplies. It counts the fixed multiplier latency, commits the 64-bit product to HI/LO, and stalls MFHI/MFLO reads while a multiply is in flight. A pipeline flush kills an in-flight multiply without touching HI/LO.

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_scheduler.sv | 131 +++++++++++++
 tb/tb_mdu_scheduler.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU scheduler: op encodings, FSM states and op-class helpers.
// The accumulate ops only count as multiplies when MDU_MADD_EN is defined.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_MTHI  = 4'd3,
      OP_MTLO  = 4'd4,
      OP_MADD  = 4'd5,
      OP_MADDU = 4'd6,
      OP_MSUB  = 4'd7,
      OP_MSUBU = 4'd8
   } mdu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } mdu_state_e;

   function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
      return op inside {OP_MULT, OP_MULTU};
`endif
   endfunction

   function automatic logic is_signed(input logic [3:0] op);
      return op inside {OP_MULT, OP_MADD, OP_MSUB};
   endfunction

   function automatic logic is_acc(input logic [3:0] op);
      return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic is_sub(input logic [3:0] op);
      return op inside {OP_MSUB, OP_MSUBU};
   endfunction

endpackage

// File: rtl/mdu_scheduler.sv
// Sequences the pipelined multiplier for EX and owns HI/LO; flush kills an in-flight multiply.
// Optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulation into HI/LO at commit.
module mdu_scheduler
   import mdu_pkg::*;
#(
   parameter int LATENCY = 5,
   parameter int CNT_W   = 4
) (
   input  logic        Clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   input  logic        flush,
   input  logic        rd_valid,
   input  logic        rd_sel,
   output logic [31:0] rd_data,
   output logic        rd_stall,
   output logic        busy,
   output logic        mul_start,
   output logic        mul_sign,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic             accept;
   logic [63:0]      commit_val;
`ifdef MDU_MADD_EN
   logic             acc_q, acc_d, sub_q, sub_d;
`endif

   assign req_ready = (state_q == IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign mul_start = accept && is_mul(req_op);
   assign mul_sign  = is_signed(req_op);
   assign mul_a     = req_a;
   assign mul_b     = req_b;
   assign busy      = (state_q == MUL);
   assign rd_stall  = rd_valid && busy;
   assign rd_data   = rd_sel ? hi_q : lo_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

   // The accumulate base is whatever HI/LO hold at commit, not at launch.
   always_comb begin
`ifdef MDU_MADD_EN
      if (!acc_q)
         commit_val = mul_result;
      else if (sub_q)
         commit_val = {hi_q, lo_q} - mul_result;
      else
         commit_val = {hi_q, lo_q} + mul_result;
`else
      commit_val = mul_result;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MDU_MADD_EN
      acc_d   = acc_q;
      sub_d   = sub_q;
`endif
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (is_mul(req_op)) begin
                     state_d = MUL;
                     cnt_d   = CNT_W'(LATENCY - 1);
`ifdef MDU_MADD_EN
                     acc_d   = is_acc(req_op);
                     sub_d   = is_sub(req_op);
`endif
                  end else if (req_op == OP_MTHI) begin
                     hi_d = req_a;
                  end else if (req_op == OP_MTLO) begin
                     lo_d = req_a;
                  end
               end
            end
            MUL: begin
               if (cnt_q == '0) begin
                  {hi_d, lo_d} = commit_val;
                  state_d      = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MDU_MADD_EN
         acc_q   <= 1'b0;
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MDU_MADD_EN
         acc_q   <= acc_d;
         sub_q   <= sub_d;
`endif
      end
   end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler (LATENCY=5 main instance, LATENCY=1 side instance).
// MDU_MADD_EN selects between accumulate checks and accumulate-as-NOP checks.
module tb_mdu_scheduler;
   import mdu_pkg::*;

   localparam int LAT = 5;
   localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

   logic        Clk = 1'b0;
   logic        resetn;
   logic        req_valid, flush, rd_valid, rd_sel;
   logic [3:0]  req_op;
   logic [31:0] req_a, req_b;

   logic        req_ready, rd_stall, busy, mul_start, mul_sign;
   logic [31:0] rd_data, mul_a, mul_b, hi, lo;
   logic [63:0] mul_result;

   logic        req_ready1, rd_stall1, busy1, mul_start1, mul_sign1;
   logic [31:0] rd_data1, mul_a1, mul_b1, hi1, lo1;
   logic [63:0] mul_result1;

   logic [63:0] pipe [LAT];
   logic [63:0] pipe1;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   mdu_scheduler #(.LATENCY(LAT), .CNT_W(4)) dut (
      .Clk(Clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
      .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_data(rd_data), .rd_stall(rd_stall),
      .busy(busy), .mul_start(mul_start), .mul_sign(mul_sign), .mul_a(mul_a),
      .mul_b(mul_b), .mul_result(mul_result), .hi(hi), .lo(lo)
   );

   mdu_scheduler #(.LATENCY(1), .CNT_W(4)) dut1 (
      .Clk(Clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready1), .flush(flush),
      .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_data(rd_data1), .rd_stall(rd_stall1),
      .busy(busy1), .mul_start(mul_start1), .mul_sign(mul_sign1), .mul_a(mul_a1),
      .mul_b(mul_b1), .mul_result(mul_result1), .hi(hi1), .lo(lo1)
   );

   function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = 64'($signed(a));
         sb = 64'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Behavioural multipliers: product emerges LATENCY cycles after the launch cycle, junk otherwise.
   always @(posedge Clk) begin
      pipe[0] <= mul_start ? prod(mul_a, mul_b, mul_sign) : JUNK;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      pipe1 <= mul_start1 ? prod(mul_a1, mul_b1, mul_sign1) : JUNK;
   end
   assign mul_result  = pipe[LAT-1];
   assign mul_result1 = pipe1;

   typedef struct {
      logic        v;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        fl, rv, rs;
      logic        eReady, eBusy, eStart, eSign, eStall;
      logic [31:0] eRd, eHi, eLo;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic fl, input logic rv, input logic rs,
                               input logic eReady, input logic eBusy, input logic eStart,
                               input logic eSign, input logic eStall, input logic [31:0] eRd,
                               input logic [31:0] eHi, input logic [31:0] eLo);
      vec_t t;
      t.v = v; t.op = op; t.a = a; t.b = b; t.fl = fl; t.rv = rv; t.rs = rs;
      t.eReady = eReady; t.eBusy = eBusy; t.eStart = eStart; t.eSign = eSign;
      t.eStall = eStall; t.eRd = eRd; t.eHi = eHi; t.eLo = eLo;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic setReq(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl);
      req_valid = v; req_op = op; req_a = a; req_b = b; flush = fl;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t t);
      setReq(t.v, t.op, t.a, t.b, t.fl);
      rd_valid = t.rv;
      rd_sel   = t.rs;
   endtask

   task automatic checkOutput(input vec_t t, input int idx);
      chk($sformatf("v%0d.ready", idx), 64'(req_ready), 64'(t.eReady));
      chk($sformatf("v%0d.busy", idx), 64'(busy), 64'(t.eBusy));
      chk($sformatf("v%0d.start", idx), 64'(mul_start), 64'(t.eStart));
      chk($sformatf("v%0d.stall", idx), 64'(rd_stall), 64'(t.eStall));
      chk($sformatf("v%0d.hi", idx), 64'(hi), 64'(t.eHi));
      chk($sformatf("v%0d.lo", idx), 64'(lo), 64'(t.eLo));
      if (t.rv) chk($sformatf("v%0d.rd_data", idx), 64'(rd_data), 64'(t.eRd));
      if (t.eStart) begin
         chk($sformatf("v%0d.sign", idx), 64'(mul_sign), 64'(t.eSign));
         chk($sformatf("v%0d.mul_a", idx), 64'(mul_a), 64'(t.a));
         chk($sformatf("v%0d.mul_b", idx), 64'(mul_b), 64'(t.b));
      end
   endtask

   initial begin
      resetn = 1'b0;
      setReq(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
      rd_valid = 1'b0;
      rd_sel   = 1'b0;

      // Vector table: one row per cycle, expectations sampled mid-cycle.
      vq.push_back(mk(0, OP_NOP,   0, 0, 0, 1, 0,  1,0,0,0,0, 32'h0, 32'h0, 32'h0));
      vq.push_back(mk(1, OP_MTHI,  32'h12345678, 0, 0, 0, 0,  1,0,0,0,0, 0, 32'h0, 32'h0));
      vq.push_back(mk(1, OP_MTLO,  32'h9ABCDEF0, 0, 0, 0, 0,  1,0,0,0,0, 0, 32'h12345678, 32'h0));
      vq.push_back(mk(0, OP_NOP,   0, 0, 0, 1, 1,  1,0,0,0,0, 32'h12345678, 32'h12345678, 32'h9ABCDEF0));
      vq.push_back(mk(1, OP_NOP,   0, 0, 0, 1, 0,  1,0,0,0,0, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0));
      vq.push_back(mk(1, OP_MULT,  32'hFFFFFFFF, 32'h2, 0, 0, 0,  1,0,1,1,0, 0, 32'h12345678, 32'h9ABCDEF0));
      for (int i = 0; i < LAT; i++)
         vq.push_back(mk(1, OP_MTHI, 0, 0, 0, 1, 1,  0,1,0,0,1, 32'h12345678, 32'h12345678, 32'h9ABCDEF0));
      vq.push_back(mk(0, OP_NOP,   0, 0, 0, 1, 1,  1,0,0,0,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE));
      vq.push_back(mk(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0,  1,0,1,0,0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE));
      vq.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0,  0,1,0,0,0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE));
      for (int i = 0; i < LAT - 1; i++)
         vq.push_back(mk(0, OP_NOP, 0, 0, 0, 1, 1,  0,1,0,0,1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE));
      vq.push_back(mk(0, OP_NOP,   0, 0, 0, 1, 1,  1,0,0,0,0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000001));
      vq.push_back(mk(1, OP_MTLO,  32'h55, 0, 1, 0, 0,  0,0,0,0,0, 0, 32'hFFFFFFFE, 32'h00000001));
      vq.push_back(mk(0, OP_NOP,   0, 0, 0, 1, 0,  1,0,0,0,0, 32'h00000001, 32'hFFFFFFFE, 32'h00000001));

      @(negedge Clk);
      chk("reset.hi", 64'(hi), 64'd0);
      chk("reset.lo", 64'(lo), 64'd0);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.start", 64'(mul_start), 64'd0);
      tick();
      resetn = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         applyStimulus(vq[i]);
         @(negedge Clk);
         checkOutput(vq[i], i);
         tick();
      end

      // Flush kills an in-flight MULT; HI/LO keep FFFFFFFE/00000001 and the late product is ignored.
      setReq(1, OP_MULT, 32'd3, 32'd4, 0);
      @(negedge Clk); chk("fl.start", 64'(mul_start), 64'd1);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      @(negedge Clk); chk("fl.busy1", 64'(busy), 64'd1);
      tick(); tick();
      setReq(1, OP_MTLO, 32'h55, 0, 1);
      @(negedge Clk);
      chk("fl.ready", 64'(req_ready), 64'd0);
      chk("fl.busy3", 64'(busy), 64'd1);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      for (int c = 4; c <= 6; c++) begin
         @(negedge Clk);
         chk($sformatf("fl.c%0d.busy", c), 64'(busy), 64'd0);
         chk($sformatf("fl.c%0d.hilo", c), {hi, lo}, 64'hFFFFFFFE_00000001);
         tick();
      end

      // LATENCY=1 instance commits after one MUL cycle; main instance commits after LAT.
      setReq(1, OP_MULT, 32'd5, 32'd9, 0);
      @(negedge Clk); chk("l1.start", 64'(mul_start1), 64'd1);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      @(negedge Clk); chk("l1.busy", 64'(busy1), 64'd1);
      tick();
      @(negedge Clk);
      chk("l1.done", 64'(busy1), 64'd0);
      chk("l1.hilo", {hi1, lo1}, 64'd45);
      chk("l1.main_busy", 64'(busy), 64'd1);
      repeat (LAT - 1) tick();
      @(negedge Clk);
      chk("l5.busy", 64'(busy), 64'd0);
      chk("l5.hilo", {hi, lo}, 64'd45);

      // Async reset mid-MUL clears HI/LO and busy at once, then a fresh MULT works.
      tick();
      setReq(1, OP_MULT, 32'd2, 32'd3, 0);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      tick();
      resetn = 1'b0;
      #1;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.hilo", {hi, lo}, 64'd0);
      tick();
      resetn = 1'b1;
      setReq(1, OP_MULT, 32'd7, 32'd6, 0);
      @(negedge Clk); chk("rst.start", 64'(mul_start), 64'd1);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      repeat (LAT) tick();
      @(negedge Clk);
      chk("rst.busy_after", 64'(busy), 64'd0);
      chk("rst.hilo_after", {hi, lo}, 64'd42);
      tick();

`ifdef MDU_MADD_EN
      setReq(1, OP_MTHI, 32'h0, 0, 0); tick();
      setReq(1, OP_MTLO, 32'h10, 0, 0); tick();
      setReq(1, OP_MSUB, 32'd2, 32'd3, 0);
      @(negedge Clk);
      chk("msub.start", 64'(mul_start), 64'd1);
      chk("msub.sign", 64'(mul_sign), 64'd1);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      @(negedge Clk); chk("msub.busy", 64'(busy), 64'd1);
      repeat (LAT) tick();
      @(negedge Clk); chk("msub.hilo", {hi, lo}, 64'h00000000_0000000A);
      tick();
      setReq(1, OP_MTLO, 32'h1, 0, 0); tick();
      setReq(1, OP_MADDU, 32'hFFFFFFFF, 32'h1, 0);
      @(negedge Clk); chk("maddu.sign", 64'(mul_sign), 64'd0);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      repeat (LAT) tick();
      @(negedge Clk); chk("maddu.hilo", {hi, lo}, 64'h00000001_00000000);
      tick();
`else
      setReq(1, OP_MTLO, 32'h10, 0, 0); tick();
      setReq(1, OP_MADD, 32'd2, 32'd3, 0);
      @(negedge Clk);
      chk("madd_nop.ready", 64'(req_ready), 64'd1);
      chk("madd_nop.start", 64'(mul_start), 64'd0);
      tick();
      setReq(0, OP_NOP, 0, 0, 0);
      @(negedge Clk);
      chk("madd_nop.busy", 64'(busy), 64'd0);
      chk("madd_nop.hilo", {hi, lo}, 64'h00000000_00000010);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
